vmem_rect_fill_ctrl: RTL
========================

Name: vmem_rect_fill_ctrl

Overview:
Sequences writes into the video memory write port (400x240, 3-bit colour) and shares that port between two requesters. The first is the CPU's single-pixel VGA instruction path. The second is a rectangle-fill engine that converts one fill command into a raster sequence of pixel writes. The block sits between the ALU's VGA write signals and the write side of the video RAM.

Parameters:
X_WIDTH, 9, column coordinate width
Y_WIDTH, 8, row coordinate width
X_SIZE, 400, video memory columns
Y_SIZE, 240, video memory rows
ADDR_WIDTH, 17, video memory address width (row-major: Y*X_SIZE+X)
DATA_WIDTH, 3, pixel colour width {R,G,B}

Ports:
Clock  in  1  system clock, all logic on posedge
Reset  in  1  one clock; reset is synchronous and active-low
iCmdValid  in  1  fill command valid
oCmdReady  out  1  fill command accepted when iCmdValid && oCmdReady at posedge
iCmdX0  in  X_WIDTH  rectangle left column
iCmdY0  in  Y_WIDTH  rectangle top row
iCmdW  in  X_WIDTH  rectangle width in pixels
iCmdH  in  Y_WIDTH  rectangle height in pixels
iCmdColor  in  DATA_WIDTH  fill colour
iCpuWriteEnable  in  1  CPU single-pixel write request
iCpuWriteAddress  in  ADDR_WIDTH  CPU write address
iCpuDataIn  in  DATA_WIDTH  CPU write colour
oVmemWriteEnable  out  1  registered write enable to video RAM
oVmemWriteAddress  out  ADDR_WIDTH  registered write address
oVmemDataIn  out  DATA_WIDTH  registered write colour
oBusy  out  1  fill in progress (state != IDLE)
oDone  out  1  one-cycle pulse at fill completion

Behaviour:
- Reset (Reset==0 at posedge): state=IDLE; oVmemWriteEnable=0, oVmemWriteAddress=0, oVmemDataIn=0, oDone=0, oBusy=0. The command latch and counters are cleared.
- FSM has three states: IDLE, FILL, DONE.
- oCmdReady = (state==IDLE), combinational. oBusy = (state!=IDLE). oDone = (state==DONE).
- IDLE: on accept, latch the colour and the clipped rectangle, then go to FILL.
- Clipping rules:
  - If X0>=X_SIZE, Y0>=Y_SIZE, W==0 or H==0, the command is empty. Go straight to DONE with no writes.
  - Otherwise W' = min(W, X_SIZE-X0) and H' = min(H, Y_SIZE-Y0).
- FILL: raster order, left to right and then top to bottom, starting at (X0,Y0).
  - In each cycle with iCpuWriteEnable==0, issue one pixel and advance.
  - At column X0+W'-1, wrap to X0 and increment the row.
  - When pixel (X0+W'-1, Y0+H'-1) is issued, go to DONE.
  - Address generation uses a running row base (+X_SIZE per row); there is no multiplier.
- DONE: lasts exactly one cycle (oDone=1), then returns to IDLE.
- Arbitration: the CPU has fixed priority.
  - A cycle with iCpuWriteEnable=1 forwards the CPU address and data. A fill in progress stalls that cycle; its position is held and no pixel is lost or duplicated.
  - CPU writes are served in every state, including IDLE and DONE.
- Latency: every write appears on the oVmem* outputs 1 cycle after the cycle in which it wins arbitration. oVmemWriteEnable=0 in cycles with no winner; address and data hold their last values.
- Timing of a non-empty fill:
  - The fill is accepted at edge t0.
  - The first fill write is visible after edge t1.
  - With no CPU traffic, the last write is visible during the DONE cycle, coincident with oDone.
  - Total cycles from accept edge to IDLE = W'*H'+1 plus the number of CPU stall cycles.
- iCmd* is ignored while oBusy=1. A command is accepted on the same cycle as a CPU write.
- Reset asserted mid-fill aborts the fill immediately: no further writes and no oDone pulse.

Test Plan:
- Basic fill: cmd (X0=10,Y0=5,W=2,H=2,color=3'b100), no CPU traffic.
  - Required: writes at addr 2010, 2011, 2410, 2411 with data 4 on consecutive cycles.
  - Required: oDone pulses once, coincident with addr 2411; oCmdReady=1 again on the next cycle.
- CPU priority: during the basic fill, assert iCpuWriteEnable for 1 cycle (addr 500, data 3'b010) between the 2nd and 3rd pixels.
  - Required: the write sequence is 2010, 2011, 500, 2410, 2411.
  - Required: oDone is delayed by exactly 1 cycle.
- Clipping: cmd (X0=398,Y0=239,W=5,H=3,color=1).
  - Required: exactly 2 writes, addr 95998 and 95999; then oDone.
- Empty commands: W=0, and separately X0=400.
  - Required: no oVmemWriteEnable; oDone high in the cycle after accept; oBusy high for 1 cycle.
- Reset mid-fill: 10x10 fill with Reset=0 after 7 writes.
  - Required: all outputs 0 on the next cycle, no oDone, and state IDLE (oCmdReady=1 after Reset=1).
- Full screen: cmd (0,0,400,240,color=7).
  - Required: 96000 writes with addresses 0..95999 strictly incrementing, then one oDone.

Source files
------------

// File: rtl/vmem_rect_fill_ctrl.sv
// Video memory write sequencer. Shares the video RAM write port between the
// CPU single-pixel path (fixed priority) and a rectangle-fill raster engine.
module vmem_rect_fill_ctrl #(
  parameter int X_WIDTH    = 9,
  parameter int Y_WIDTH    = 8,
  parameter int X_SIZE     = 400,
  parameter int Y_SIZE     = 240,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 3
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iCmdValid,
  output logic                  oCmdReady,
  input  logic [X_WIDTH-1:0]    iCmdX0,
  input  logic [Y_WIDTH-1:0]    iCmdY0,
  input  logic [X_WIDTH-1:0]    iCmdW,
  input  logic [Y_WIDTH-1:0]    iCmdH,
  input  logic [DATA_WIDTH-1:0] iCmdColor,
  input  logic                  iCpuWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iCpuWriteAddress,
  input  logic [DATA_WIDTH-1:0] iCpuDataIn,
  output logic                  oVmemWriteEnable,
  output logic [ADDR_WIDTH-1:0] oVmemWriteAddress,
  output logic [DATA_WIDTH-1:0] oVmemDataIn,
  output logic                  oBusy,
  output logic                  oDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_WIDTH:0]      XSizeX = (X_WIDTH+1)'(X_SIZE);
  localparam logic [Y_WIDTH:0]      YSizeY = (Y_WIDTH+1)'(Y_SIZE);
  localparam logic [ADDR_WIDTH-1:0] XSizeA = ADDR_WIDTH'(X_SIZE);

  // Row base of the first row. X_SIZE is a constant, so this is a fixed
  // shift-and-add network; later rows only ever add X_SIZE to it.
  function automatic logic [ADDR_WIDTH-1:0] rowBaseOf(input logic [Y_WIDTH-1:0] y);
    logic [ADDR_WIDTH-1:0] acc;
    acc = '0;
    for (int b = 0; b < ADDR_WIDTH; b++) begin
      if (XSizeA[b]) acc = acc + (ADDR_WIDTH'(y) << b);
    end
    return acc;
  endfunction

  state_t                state_q;
  logic [X_WIDTH-1:0]    x0_q;
  logic [X_WIDTH-1:0]    curX_q;
  logic [Y_WIDTH-1:0]    curY_q;
  logic [X_WIDTH-1:0]    lastX_q;
  logic [Y_WIDTH-1:0]    lastY_q;
  logic [ADDR_WIDTH-1:0] rowBase_q;
  logic [DATA_WIDTH-1:0] color_q;
  logic                  wrEn_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [DATA_WIDTH-1:0] wrData_q;

  logic [X_WIDTH:0]      xRoom;
  logic [Y_WIDTH:0]      yRoom;
  logic [X_WIDTH-1:0]    wClip;
  logic [Y_WIDTH-1:0]    hClip;
  logic                  cmdEmpty;
  logic [X_WIDTH-1:0]    lastX_d;
  logic [Y_WIDTH-1:0]    lastY_d;
  logic [ADDR_WIDTH-1:0] fillAddr_d;

  // Clip the incoming command against the screen edges and form the
  // current fill pixel address from the running row base.
  always_comb begin
    xRoom    = XSizeX - {1'b0, iCmdX0};
    yRoom    = YSizeY - {1'b0, iCmdY0};
    wClip    = ({1'b0, iCmdW} < xRoom) ? iCmdW : xRoom[X_WIDTH-1:0];
    hClip    = ({1'b0, iCmdH} < yRoom) ? iCmdH : yRoom[Y_WIDTH-1:0];
    cmdEmpty = ({1'b0, iCmdX0} >= XSizeX) || ({1'b0, iCmdY0} >= YSizeY) ||
               (iCmdW == '0) || (iCmdH == '0);
    lastX_d  = iCmdX0 + wClip - X_WIDTH'(1);
    lastY_d  = iCmdY0 + hClip - Y_WIDTH'(1);
    fillAddr_d = rowBase_q + {{(ADDR_WIDTH-X_WIDTH){1'b0}}, curX_q};
  end

  // Fill FSM plus write-port arbitration; the CPU wins every cycle it asks,
  // which simply freezes the raster position for that cycle.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      curX_q    <= '0;
      curY_q    <= '0;
      lastX_q   <= '0;
      lastY_q   <= '0;
      rowBase_q <= '0;
      color_q   <= '0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
    end else begin
      wrEn_q <= 1'b0;
      if (iCpuWriteEnable) begin
        wrEn_q   <= 1'b1;
        wrAddr_q <= iCpuWriteAddress;
        wrData_q <= iCpuDataIn;
      end
      case (state_q)
        IDLE: begin
          if (iCmdValid) begin
            x0_q      <= iCmdX0;
            curX_q    <= iCmdX0;
            curY_q    <= iCmdY0;
            lastX_q   <= lastX_d;
            lastY_q   <= lastY_d;
            rowBase_q <= rowBaseOf(iCmdY0);
            color_q   <= iCmdColor;
            state_q   <= cmdEmpty ? DONE : FILL;
          end
        end
        FILL: begin
          if (!iCpuWriteEnable) begin
            wrEn_q   <= 1'b1;
            wrAddr_q <= fillAddr_d;
            wrData_q <= color_q;
            if (curX_q == lastX_q) begin
              if (curY_q == lastY_q) begin
                state_q <= DONE;
              end else begin
                curX_q    <= x0_q;
                curY_q    <= curY_q + Y_WIDTH'(1);
                rowBase_q <= rowBase_q + XSizeA;
              end
            end else begin
              curX_q <= curX_q + X_WIDTH'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oCmdReady         = (state_q == IDLE);
  assign oBusy             = (state_q != IDLE);
  assign oDone             = (state_q == DONE);
  assign oVmemWriteEnable  = wrEn_q;
  assign oVmemWriteAddress = wrAddr_q;
  assign oVmemDataIn       = wrData_q;

endmodule
